// File: rtl/fpga_cfg_loader.sv
// Configuration sequencer: accepts bitstream words, shifts CHAIN_LEN bits MSB-first into the
// fabric chain, then releases logic-element reset and enables the fabric.
module fpga_cfg_loader #(
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned RST_HOLD  = 4,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_data,
  output logic              cfg_shift,
  output logic              le_nrst,
  output logic              le_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned NumWords = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int unsigned BitCntW  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WcntW    = $clog2(WORD_W + 1);
  localparam int unsigned TcntW    = $clog2(TIMEOUT + 1);
  localparam int unsigned HoldW    = $clog2(RST_HOLD + 1);
  localparam int unsigned AcntW    = $clog2(NumWords + 1);

  // State bits drive the fabric-facing outputs directly from flops, so they never glitch.
  // Bit map: [5] le_nrst, [4] le_en, [3] busy, [2] done, [1] error, [0] hold tag.
  typedef enum logic [5:0] {
    StIdle  = 6'b000000,
    StLoad  = 6'b001000,
    StHold  = 6'b001001,
    StArm   = 6'b100000,
    StRun   = 6'b110100,
    StError = 6'b000010
  } state_e;

  state_e              state_q;
  logic [BitCntW-1:0]  bit_cnt_q;
  logic [WcntW-1:0]    wcnt_q;
  logic [TcntW-1:0]    tcnt_q;
  logic [HoldW-1:0]    hold_cnt_q;
  logic [AcntW-1:0]    acnt_q;
  logic [WORD_W-1:0]   shreg_q;
  logic                handshake;

  assign cfg_shift  = en && (state_q == StLoad) && (wcnt_q != '0);
  // Ready during the last bit of a word keeps back-to-back words bubble-free.
  assign word_ready = en && (state_q == StLoad)
                      && ((wcnt_q == '0) || ((wcnt_q == WcntW'(1)) && cfg_shift))
                      && (acnt_q < AcntW'(NumWords));
  assign handshake  = word_ready && word_valid;
  assign cfg_data   = shreg_q[WORD_W-1];

  assign le_nrst = state_q[5];
  assign le_en   = state_q[4];
  assign busy    = state_q[3];
  assign done    = state_q[2];
  assign error   = state_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      wcnt_q     <= '0;
      tcnt_q     <= '0;
      hold_cnt_q <= '0;
      acnt_q     <= '0;
      shreg_q    <= '0;
    end else if (en) begin
      case (state_q)
        StIdle, StRun, StError: begin
          if (start) begin
            state_q    <= StLoad;
            bit_cnt_q  <= '0;
            wcnt_q     <= '0;
            tcnt_q     <= '0;
            hold_cnt_q <= '0;
            acnt_q     <= '0;
            shreg_q    <= '0;
          end
        end
        StLoad: begin
          if (cfg_shift) begin
            shreg_q   <= {shreg_q[WORD_W-2:0], 1'b0};
            wcnt_q    <= wcnt_q - WcntW'(1);
            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
          end
          if (handshake) begin
            shreg_q <= word_in;
            wcnt_q  <= WcntW'(WORD_W);
            acnt_q  <= acnt_q + AcntW'(1);
            tcnt_q  <= '0;
          end else if (wcnt_q == '0) begin
            tcnt_q <= tcnt_q + TcntW'(1);
            if (tcnt_q == TcntW'(TIMEOUT - 1)) state_q <= StError;
          end
          // Final chain bit: drop any leftover bits of a partial last word.
          if (cfg_shift && (bit_cnt_q == BitCntW'(CHAIN_LEN - 1))) begin
            state_q <= StHold;
            wcnt_q  <= '0;
            shreg_q <= '0;
          end
        end
        StHold: begin
          hold_cnt_q <= hold_cnt_q + HoldW'(1);
          if (hold_cnt_q == HoldW'(RST_HOLD - 1)) state_q <= StArm;
        end
        StArm:   state_q <= StRun;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
